router_pkt_reader: RTL and testbench

ROUTER_PKT_READER -- requirements
Module: router_pkt_reader

---
 rtl/router_pkg.sv | 27 ++
 rtl/router_parity_chk.sv | 40 ++++
 rtl/router_pkt_reader.sv | 152 +++++++++++++++
 tb/tb_router_pkt_reader.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared types and widths for the router packet reader
//
// Purpose: state encoding, header field widths and a helper that turns the
// header length field into the number of reads still owed after the header.
// Ports: none (package).

package router_pkg;

  localparam int DATA_W     = 8;
  localparam int HDR_LEN_W  = 6;
  localparam int HDR_ADDR_W = 2;
  // One extra bit so that len=63 plus the parity byte (64) still fits.
  localparam int REM_W      = HDR_LEN_W + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HDR    = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Payload bytes plus the trailing parity byte.
  function automatic logic [REM_W-1:0] hdr_reads(input logic [HDR_LEN_W-1:0] len);
    return {1'b0, len} + REM_W'(1);
  endfunction

endpackage

// File: rtl/router_parity_chk.sv
// rtl/router_parity_chk.sv - XOR parity accumulator and final-byte compare
//
// Purpose: XORs every header/payload byte into an accumulator; when the final
// (parity) byte arrives, registers whether it disagrees with the accumulator.
// Ports:
//   clock, reset : rising-edge clock, synchronous active-high reset
//   clr          : start of a new packet, zero accumulator and error
//   en           : din carries a packet byte this cycle
//   din          : packet byte
//   last         : din is the parity byte (compare instead of accumulate)
//   err          : parity mismatch of the most recent packet

module router_parity_chk
  import router_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  input  logic              last,
  output logic              err
);

  logic [DATA_W-1:0] acc;

  always_ff @(posedge clock) begin
    if (reset || clr) begin
      acc <= '0;
      err <= 1'b0;
    end else if (en) begin
      if (last) begin
        err <= (din != acc);
      end else begin
        acc <= acc ^ din;
      end
    end
  end

endmodule

// File: rtl/router_pkt_reader.sv
// rtl/router_pkt_reader.sv - pulls one packet at a time out of a router port
//
// Purpose: reads a header, len payload bytes and a parity byte from a router
// output FIFO, presents each byte with sop/eop marks, checks parity, aborts
// on an idle timeout and keeps saturating packet/error counters.
// Ports:
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   enable              : consumer allows reads
//   valid_out, data_out : FIFO non-empty flag and read data (one cycle latency)
//   read_enb            : FIFO read strobe
//   byte_q, byte_vld    : captured byte and its valid
//   sop, eop            : byte_q is the header / parity byte
//   pkt_len, pkt_addr   : latched header fields
//   pkt_done            : one-cycle completion pulse
//   parity_err, trunc_err : packet status, qualified by pkt_done
//   pkt_cnt, err_cnt    : saturating packet and errored-packet counters

module router_pkt_reader
  import router_pkg::*;
#(
  parameter int TIMEOUT_CYC = 32,
  parameter int CNT_W       = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  valid_out,
  input  logic [DATA_W-1:0]     data_out,
  output logic                  read_enb,
  output logic [DATA_W-1:0]     byte_q,
  output logic                  byte_vld,
  output logic                  sop,
  output logic                  eop,
  output logic [HDR_LEN_W-1:0]  pkt_len,
  output logic [HDR_ADDR_W-1:0] pkt_addr,
  output logic                  pkt_done,
  output logic                  parity_err,
  output logic                  trunc_err,
  output logic [CNT_W-1:0]      pkt_cnt,
  output logic [CNT_W-1:0]      err_cnt
);

  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  state_t           state, state_nxt;
  logic             rd_pend;     // a read was issued last cycle, data_out holds its byte
  logic [REM_W-1:0] remaining;   // reads owed after the header
  logic [REM_W-1:0] issued;      // post-header reads issued
  logic [REM_W-1:0] rcvd;        // post-header bytes captured
  logic [TO_W-1:0]  to_cnt;
  logic             last_byte;
  logic             to_count;
  logic             timeout;

  always_comb begin
    state_nxt = state;
    read_enb  = 1'b0;
    to_count  = 1'b0;
    timeout   = 1'b0;
    last_byte = rd_pend && (state == STREAM) && (rcvd == remaining - REM_W'(1));
    case (state)
      IDLE: begin
        if (valid_out && enable) begin
          read_enb  = 1'b1;
          state_nxt = HDR;
        end
      end
      HDR: state_nxt = STREAM;
      STREAM: begin
        read_enb = valid_out && enable && (issued < remaining);
        to_count = enable && !valid_out;
        // Never abort with a byte still in flight; it always lands first.
        timeout  = to_count && !rd_pend && (to_cnt == TO_W'(TIMEOUT_CYC - 1));
        if (last_byte || timeout) state_nxt = DONE;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (reset) read_enb = 1'b0;
  end

  assign pkt_done = (state == DONE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      rd_pend   <= 1'b0;
      remaining <= '0;
      issued    <= '0;
      rcvd      <= '0;
      to_cnt    <= '0;
      byte_q    <= '0;
      byte_vld  <= 1'b0;
      sop       <= 1'b0;
      eop       <= 1'b0;
      pkt_len   <= '0;
      pkt_addr  <= '0;
      trunc_err <= 1'b0;
      pkt_cnt   <= '0;
      err_cnt   <= '0;
    end else begin
      state    <= state_nxt;
      rd_pend  <= read_enb;
      byte_vld <= rd_pend;
      sop      <= rd_pend && (state == HDR);
      eop      <= last_byte;
      if (rd_pend) byte_q <= data_out;

      if (state == HDR) begin
        pkt_len   <= data_out[DATA_W-1 -: HDR_LEN_W];
        pkt_addr  <= data_out[HDR_ADDR_W-1:0];
        remaining <= hdr_reads(data_out[DATA_W-1 -: HDR_LEN_W]);
        issued    <= '0;
        rcvd      <= '0;
      end

      if (state == STREAM) begin
        if (read_enb) issued <= issued + REM_W'(1);
        if (rd_pend)  rcvd   <= rcvd + REM_W'(1);
      end

      // enable=0 leaves to_count low, which freezes the counter.
      if (read_enb || (state != STREAM)) begin
        to_cnt <= '0;
      end else if (to_count) begin
        to_cnt <= to_cnt + TO_W'(1);
      end

      if ((state == IDLE) && read_enb) begin
        trunc_err <= 1'b0;
      end else if (timeout) begin
        trunc_err <= 1'b1;
      end

      if (state == DONE) begin
        if (pkt_cnt != '1) pkt_cnt <= pkt_cnt + CNT_W'(1);
        if ((parity_err || trunc_err) && (err_cnt != '1)) err_cnt <= err_cnt + CNT_W'(1);
      end
    end
  end

  router_parity_chk u_parity (
    .clock (clock),
    .reset (reset),
    .clr   ((state == IDLE) && read_enb),
    .en    (rd_pend && ((state == HDR) || (state == STREAM))),
    .din   (data_out),
    .last  (last_byte),
    .err   (parity_err)
  );

endmodule

// File: tb/tb_router_pkt_reader.sv
// tb/tb_router_pkt_reader.sv - self-checking bench for router_pkt_reader

module tb_router_pkt_reader;

  localparam int TIMEOUT_CYC = 32;
  localparam int CNT_W       = 8;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic       valid_out;
  logic [7:0] data_out;
  logic       read_enb;
  logic [7:0] byte_q;
  logic       byte_vld, sop, eop;
  logic [5:0] pkt_len;
  logic [1:0] pkt_addr;
  logic       pkt_done, parity_err, trunc_err;
  logic [CNT_W-1:0] pkt_cnt, err_cnt;

  router_pkt_reader #(.TIMEOUT_CYC(TIMEOUT_CYC), .CNT_W(CNT_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .valid_out  (valid_out),
    .data_out   (data_out),
    .read_enb   (read_enb),
    .byte_q     (byte_q),
    .byte_vld   (byte_vld),
    .sop        (sop),
    .eop        (eop),
    .pkt_len    (pkt_len),
    .pkt_addr   (pkt_addr),
    .pkt_done   (pkt_done),
    .parity_err (parity_err),
    .trunc_err  (trunc_err),
    .pkt_cnt    (pkt_cnt),
    .err_cnt    (err_cnt)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] hdr;
    bit         corrupt;     // invert the parity byte
    int         stall_kind;  // 0 none, 1 drop valid_out, 2 drop enable
    int         stall_at;    // payload bytes read before the stall
    int         stall_len;   // stall cycles (valid drop is held until pkt_done when trunc expected)
    bit         exp_perr;
    bit         exp_trunc;
    int         exp_bytes;   // byte_vld cycles and FIFO reads expected
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] fifo[$];
  logic [9:0] obs_q[$];
  bit  hold;
  int  cyc, pop_cnt, rd_cnt, first_rd_cyc, last_rd_cyc;
  int  done_seen, done_cyc;
  logic done_perr, done_trunc, done_rd;
  logic [5:0] done_len;
  logic [1:0] done_addr;
  int  exp_pkt, exp_err;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Samples outputs mid-cycle, then plays the FIFO: data appears one cycle after a read.
  task automatic step();
    logic rd;
    @(negedge clock);
    if (byte_vld) obs_q.push_back({sop, eop, byte_q});
    if (pkt_done) begin
      done_seen++;
      done_cyc   = cyc;
      done_perr  = parity_err;
      done_trunc = trunc_err;
      done_len   = pkt_len;
      done_addr  = pkt_addr;
      done_rd    = read_enb;
    end
    rd = read_enb;
    if (rd) begin
      chk("read_while_not_valid", 32'(valid_out), 32'd1);
      if (rd_cnt == 0) first_rd_cyc = cyc;
      rd_cnt++;
      last_rd_cyc = cyc;
    end
    cyc++;
    @(posedge clock);
    #1;
    if (rd && fifo.size() != 0) begin
      data_out = fifo.pop_front();
      pop_cnt++;
    end else begin
      data_out = 8'($urandom);
    end
    valid_out = (fifo.size() != 0) && !hold;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_read_enb"},   32'(read_enb),   32'd0);
    chk({tag, "_byte_vld"},   32'(byte_vld),   32'd0);
    chk({tag, "_sop"},        32'(sop),        32'd0);
    chk({tag, "_eop"},        32'(eop),        32'd0);
    chk({tag, "_pkt_done"},   32'(pkt_done),   32'd0);
    chk({tag, "_parity_err"}, 32'(parity_err), 32'd0);
    chk({tag, "_trunc_err"},  32'(trunc_err),  32'd0);
    chk({tag, "_byte_q"},     32'(byte_q),     32'd0);
    chk({tag, "_pkt_len"},    32'(pkt_len),    32'd0);
    chk({tag, "_pkt_addr"},   32'(pkt_addr),   32'd0);
    chk({tag, "_pkt_cnt"},    32'(pkt_cnt),    32'd0);
    chk({tag, "_err_cnt"},    32'(err_cnt),    32'd0);
  endtask

  // Builds header + payload + XOR parity (+1 spare byte that must not be read).
  task automatic load_pkt(input logic [7:0] hdr, input bit corrupt, output logic [7:0] pkt[$]);
    logic [7:0] par;
    logic [7:0] b;
    pkt.delete();
    pkt.push_back(hdr);
    par = hdr;
    for (int i = 0; i < int'(hdr[7:2]); i++) begin
      b = 8'($urandom);
      pkt.push_back(b);
      par ^= b;
    end
    pkt.push_back(corrupt ? ~par : par);
    foreach (pkt[i]) fifo.push_back(pkt[i]);
    fifo.push_back(8'($urandom));
  endtask

  task automatic run_pkt(input vec_t v);
    logic [7:0] pkt[$];
    int len, stall_left;
    bit stalled;
    len = int'(v.hdr[7:2]);
    load_pkt(v.hdr, v.corrupt, pkt);
    obs_q.delete();
    done_seen = 0; rd_cnt = 0; pop_cnt = 0;
    stalled = 1'b0; stall_left = 0;
    valid_out = !hold;
    for (int c = 0; c < 600 && done_seen == 0; c++) begin
      step();
      if (!stalled && v.stall_kind != 0 && pop_cnt == 1 + v.stall_at) begin
        stalled = 1'b1;
        stall_left = v.stall_len;
        if (v.stall_kind == 1) hold = 1'b1;
        else enable = 1'b0;
      end else if (stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) begin
          hold = 1'b0;
          enable = 1'b1;
        end
      end
      valid_out = (fifo.size() != 0) && !hold;
    end
    fifo.delete();
    hold = 1'b0;
    enable = 1'b1;
    valid_out = 1'b0;

    if (exp_pkt < CNT_MAX) exp_pkt++;
    if ((v.exp_perr || v.exp_trunc) && exp_err < CNT_MAX) exp_err++;

    chk("pkt_done_pulses", 32'(done_seen), 32'd1);
    chk("byte_count", 32'(obs_q.size()), 32'(v.exp_bytes));
    for (int i = 0; i < obs_q.size() && i < v.exp_bytes; i++)
      chk("byte_sop_eop", 32'(obs_q[i]), 32'({1'(i == 0), 1'(i == len + 1), pkt[i]}));
    chk("read_count", 32'(rd_cnt), 32'(v.exp_bytes));
    chk("pkt_len", 32'(done_len), 32'(len));
    chk("pkt_addr", 32'(done_addr), 32'(v.hdr[1:0]));
    chk("trunc_err", 32'(done_trunc), 32'(v.exp_trunc));
    if (!v.exp_trunc) chk("parity_err", 32'(done_perr), 32'(v.exp_perr));
    chk("read_in_done", 32'(done_rd), 32'd0);
    if (v.stall_kind == 0) chk("done_latency", 32'(done_cyc - first_rd_cyc), 32'(len + 4));
    if (v.exp_trunc) chk("timeout_latency", 32'(done_cyc - last_rd_cyc), 32'(TIMEOUT_CYC + 1));
    chk("pkt_cnt", 32'(pkt_cnt), 32'(exp_pkt));
    chk("err_cnt", 32'(err_cnt), 32'(exp_err));
  endtask

  vec_t tbl[8];
  vec_t rv;

  initial begin
    logic [7:0] pkt[$];
    int len;

    tbl[0] = '{8'h39, 1'b0, 0, 0, 0,    1'b0, 1'b0, 16};
    tbl[1] = '{8'h15, 1'b1, 0, 0, 0,    1'b1, 1'b0, 7};
    tbl[2] = '{8'h01, 1'b0, 0, 0, 0,    1'b0, 1'b0, 2};
    tbl[3] = '{8'h50, 1'b0, 1, 8, 200,  1'b0, 1'b1, 9};
    tbl[4] = '{8'h28, 1'b0, 2, 4, 50,   1'b0, 1'b0, 12};
    tbl[5] = '{8'h2E, 1'b0, 1, 3, 20,   1'b0, 1'b0, 13};
    tbl[6] = '{8'hFF, 1'b1, 0, 0, 0,    1'b1, 1'b0, 65};
    tbl[7] = '{8'h0C, 1'b0, 1, 2, 31,   1'b0, 1'b0, 5};

    reset = 1'b1; enable = 1'b1; hold = 1'b0; valid_out = 1'b0; data_out = 8'h00;
    cyc = 0; pop_cnt = 0; rd_cnt = 0; done_seen = 0;
    exp_pkt = 0; exp_err = 0;
    repeat (3) step();
    check_zero("reset");
    reset = 1'b0;

    // Reset in the middle of a payload: nothing completes, counters stay clear.
    load_pkt(8'h28, 1'b0, pkt);
    obs_q.delete();
    valid_out = 1'b1;
    for (int c = 0; c < 100 && obs_q.size() < 4; c++) step();
    chk("pre_reset_bytes", 32'(obs_q.size()), 32'd4);
    reset = 1'b1;
    step();
    check_zero("mid_reset");
    chk("mid_reset_no_done", 32'(done_seen), 32'd0);
    fifo.delete();
    valid_out = 1'b0;
    reset = 1'b0;
    repeat (2) step();
    chk("post_reset_no_done", 32'(done_seen), 32'd0);
    chk("post_reset_pkt_cnt", 32'(pkt_cnt), 32'd0);

    for (int i = 0; i < 8; i++) run_pkt(tbl[i]);

    for (int i = 0; i < 24; i++) begin
      rv.hdr        = 8'($urandom);
      len           = int'(rv.hdr[7:2]);
      rv.corrupt    = 1'($urandom);
      rv.stall_kind = int'($urandom_range(0, 2));
      rv.stall_at   = int'($urandom_range(0, len));
      rv.stall_len  = (rv.stall_kind == 1) ? int'($urandom_range(1, TIMEOUT_CYC - 1))
                                           : int'($urandom_range(1, 60));
      rv.exp_perr   = rv.corrupt;
      rv.exp_trunc  = 1'b0;
      rv.exp_bytes  = len + 2;
      run_pkt(rv);
    end

    for (int i = 0; i < 260; i++) run_pkt('{8'h01, 1'b1, 0, 0, 0, 1'b1, 1'b0, 2});
    chk("pkt_cnt_saturated", 32'(pkt_cnt), 32'(CNT_MAX));
    chk("err_cnt_saturated", 32'(err_cnt), 32'(CNT_MAX));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
